// File: rtl/bmem_responder_pkg.sv
// Shared types and constants for the bmem burst responder.
package bmem_responder_pkg;

    localparam int unsigned BMEM_BEATS      = 4;
    localparam int unsigned BMEM_BEAT_BITS  = 64;
    localparam int unsigned BMEM_LINE_BITS  = 256;
    localparam int unsigned BMEM_ADDR_BITS  = 32;
    localparam int unsigned BMEM_LADDR_BITS = 27;
    // Stamp storage is wider than any practical compare width; only the low bits are compared.
    localparam int unsigned BMEM_STAMP_BITS = 16;

    typedef struct packed {
        logic [BMEM_LADDR_BITS-1:0] line_addr;
        logic [BMEM_LINE_BITS-1:0]  data;
        logic [BMEM_STAMP_BITS-1:0] stamp;
    } bmem_rd_entry_t;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } bmem_rstate_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_B1,
        W_B2,
        W_B3
    } bmem_wstate_e;

    // Beat k of a line occupies bits [64k +: 64].
    function automatic logic [BMEM_BEAT_BITS-1:0] bmem_beat(input logic [BMEM_LINE_BITS-1:0] line,
                                                            input logic [1:0]                k);
        return line[{k, 6'b0} +: BMEM_BEAT_BITS];
    endfunction

endpackage

// File: rtl/bmem_responder_if.sv
// Request/response signals of the bmem burst port.
interface bmem_responder_if;
    import bmem_responder_pkg::*;

    logic [BMEM_ADDR_BITS-1:0] addr;
    logic                      read;
    logic                      write;
    logic [BMEM_BEAT_BITS-1:0] wdata;
    logic                      ready;
    logic [BMEM_ADDR_BITS-1:0] raddr;
    logic [BMEM_BEAT_BITS-1:0] rdata;
    logic                      rvalid;

    modport master (
        output addr, read, write, wdata,
        input  ready, raddr, rdata, rvalid
    );

    modport slave (
        input  addr, read, write, wdata,
        output ready, raddr, rdata, rvalid
    );

endinterface

// File: rtl/bmem_responder_rd_fifo.sv
// Outstanding-read queue: wrap-around FIFO exposing the head and the entry behind it.
module bmem_responder_rd_fifo
    import bmem_responder_pkg::*;
#(
    parameter int unsigned  DEPTH = 4,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNTW  = AW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  bmem_rd_entry_t  push_data_i,
    input  logic            pop_i,
    output bmem_rd_entry_t  head_c,
    output bmem_rd_entry_t  next_c,
    output logic [CNTW-1:0] count_o,
    output logic            full_c,
    output logic            empty_c
);

    bmem_rd_entry_t  mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            push_ok_c, pop_ok_c;

    // Pointer/count update; pushes into a full queue and pops of an empty one are ignored.
    always_comb begin
        full_c    = (count_q == CNTW'(DEPTH));
        empty_c   = (count_q == '0);
        push_ok_c = push_i && !full_c;
        pop_ok_c  = pop_i && !empty_c;
        wr_ptr_d  = wr_ptr_q + AW'(push_ok_c);
        rd_ptr_d  = rd_ptr_q + AW'(pop_ok_c);
        count_d   = count_q + CNTW'(push_ok_c) - CNTW'(pop_ok_c);
        head_c    = mem_q[rd_ptr_q];
        next_c    = mem_q[rd_ptr_q + AW'(1)];
        count_o   = count_q;
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, not reset.
    always_ff @(posedge clk) begin
        if (push_ok_c && !rst) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/bmem_responder.sv
// Line-granular backing store answering bmem read/write line bursts with fixed read latency.
module bmem_responder
    import bmem_responder_pkg::*;
#(
    parameter int unsigned  MEM_LINES = 1024,
    parameter int unsigned  LATENCY   = 8,
    parameter int unsigned  QDEPTH    = 4,
    localparam int unsigned IW        = $clog2(MEM_LINES)
) (
    input  logic                      clk,
    input  logic                      rst,
    bmem_responder_if.slave           bus,
    input  logic                      load_en,
    input  logic [IW-1:0]             load_idx,
    input  logic [BMEM_LINE_BITS-1:0] load_data
);

    localparam int unsigned CW  = $clog2(LATENCY) + 2;
    localparam int unsigned QCW = ((QDEPTH > 1) ? $clog2(QDEPTH) : 1) + 1;

    logic [BMEM_LINE_BITS-1:0]  mem [MEM_LINES];

    logic                       rst_q;
    logic [CW-1:0]              cnt_q;

    bmem_wstate_e               wstate_q, wstate_d;
    logic [191:0]               wbuf_q, wbuf_d;
    logic [BMEM_LADDR_BITS-1:0] waddr_q, waddr_d;

    bmem_rstate_e               rstate_q, rstate_d;
    logic [1:0]                 beat_q, beat_d;
    logic                       rvalid_q, rvalid_d;
    logic [BMEM_BEAT_BITS-1:0]  rdata_q, rdata_d;
    logic [BMEM_ADDR_BITS-1:0]  raddr_q, raddr_d;

    logic                       ready_c, push_c, pop_c, commit_c;
    logic                       head_elig_c, next_elig_c;
    logic [BMEM_LINE_BITS-1:0]  commit_line_c, rd_line_c;
    logic [IW-1:0]              commit_idx_c, rd_idx_c;
    bmem_rd_entry_t             push_entry_c, head_c, next_c;
    logic [QCW-1:0]             q_count;
    logic                       q_full_c, q_empty_c;
    logic                       unused_bits;

    assign unused_bits = ^{bus.addr[4:0], head_c.stamp, next_c.stamp};

    bmem_responder_rd_fifo #(.DEPTH(QDEPTH)) u_rd_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push_c),
        .push_data_i(push_entry_c),
        .pop_i      (pop_c),
        .head_c     (head_c),
        .next_c     (next_c),
        .count_o    (q_count),
        .full_c     (q_full_c),
        .empty_c    (q_empty_c)
    );

    // Accept/sample logic; ready depends only on registered state (queue count checked before any pop).
    always_comb begin
        ready_c       = !rst_q && !q_full_c && (wstate_q == W_IDLE);
        push_c        = bus.read && ready_c && !bus.write;
        commit_line_c = {bus.wdata, wbuf_q};
        commit_idx_c  = waddr_q[IW-1:0];
        rd_idx_c      = bus.addr[5 +: IW];
        rd_line_c     = (commit_c && (commit_idx_c == rd_idx_c)) ? commit_line_c : mem[rd_idx_c];
        push_entry_c  = '{line_addr: bus.addr[31:5],
                          data:      rd_line_c,
                          stamp:     BMEM_STAMP_BITS'(cnt_q)};
        head_elig_c   = !q_empty_c && (CW'(cnt_q - CW'(head_c.stamp)) >= CW'(LATENCY));
        next_elig_c   = (q_count >= QCW'(2)) && (CW'(cnt_q - CW'(next_c.stamp)) >= CW'(LATENCY));
    end

    assign bus.ready  = ready_c;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;
    assign bus.raddr  = raddr_q;

    // Write FSM: collect four beats, commit on the last; a gap in write aborts the line.
    always_comb begin
        wstate_d = wstate_q;
        wbuf_d   = wbuf_q;
        waddr_d  = waddr_q;
        commit_c = 1'b0;
        unique case (wstate_q)
            W_IDLE: begin
                if (bus.write && ready_c) begin
                    wbuf_d[63:0] = bus.wdata;
                    waddr_d      = bus.addr[31:5];
                    wstate_d     = W_B1;
                end
            end
            W_B1: begin
                wbuf_d[127:64] = bus.wdata;
                wstate_d       = bus.write ? W_B2 : W_IDLE;
            end
            W_B2: begin
                wbuf_d[191:128] = bus.wdata;
                wstate_d        = bus.write ? W_B3 : W_IDLE;
            end
            W_B3: begin
                commit_c = bus.write && !rst;
                wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Read-issue FSM: in-order 4-beat bursts, next eligible entry follows beat 3 without a bubble.
    always_comb begin
        rstate_d = rstate_q;
        beat_d   = beat_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        raddr_d  = raddr_q;
        pop_c    = 1'b0;
        unique case (rstate_q)
            R_IDLE: begin
                if (head_elig_c) begin
                    rstate_d = R_BURST;
                    beat_d   = 2'd0;
                    rvalid_d = 1'b1;
                    rdata_d  = bmem_beat(head_c.data, 2'd0);
                    raddr_d  = {head_c.line_addr, 5'b0};
                end
            end
            R_BURST: begin
                if (beat_q != 2'd3) begin
                    beat_d   = beat_q + 2'd1;
                    rvalid_d = 1'b1;
                    rdata_d  = bmem_beat(head_c.data, beat_q + 2'd1);
                end else begin
                    pop_c  = 1'b1;
                    beat_d = 2'd0;
                    if (next_elig_c) begin
                        rvalid_d = 1'b1;
                        rdata_d  = bmem_beat(next_c.data, 2'd0);
                        raddr_d  = {next_c.line_addr, 5'b0};
                    end else begin
                        rstate_d = R_IDLE;
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_q    <= 1'b1;
            cnt_q    <= '0;
            wstate_q <= W_IDLE;
            wbuf_q   <= '0;
            waddr_q  <= '0;
            rstate_q <= R_IDLE;
            beat_q   <= 2'd0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            raddr_q  <= '0;
        end else begin
            rst_q    <= 1'b0;
            cnt_q    <= cnt_q + CW'(1);
            wstate_q <= wstate_d;
            wbuf_q   <= wbuf_d;
            waddr_q  <= waddr_d;
            rstate_q <= rstate_d;
            beat_q   <= beat_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            raddr_q  <= raddr_d;
        end
    end

    // Backing store; a burst commit beats a backdoor load to the same line.
    always_ff @(posedge clk) begin
        if (commit_c) begin
            mem[commit_idx_c] <= commit_line_c;
        end
        if (load_en && !(commit_c && (load_idx == commit_idx_c))) begin
            mem[load_idx] <= load_data;
        end
    end

    // Address must stay on one line while a write burst is in flight.
    a_wr_addr_stable: assert property (@(posedge clk) disable iff (rst)
        ((wstate_q != W_IDLE) && bus.write) |-> (bus.addr[31:5] == waddr_q));

    // A burst never runs past its fourth beat.
    a_rvalid_run: assert property (@(posedge clk) disable iff (rst)
        (rvalid_q && (beat_q == 2'd3)) |=> (!rvalid_q || (beat_q == 2'd0)));

endmodule

// File: tb/tb_bmem_responder.sv
// Directed bench for bmem_responder: table of reads plus multi-cycle corner sequences.
module tb_bmem_responder;

    localparam int unsigned LAT = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_en;
    logic [9:0]   load_idx;
    logic [255:0] load_data;

    bmem_responder_if bus();

    bmem_responder #(.MEM_LINES(1024), .LATENCY(LAT), .QDEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .load_en  (load_en),
        .load_idx (load_idx),
        .load_data(load_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    logic [63:0] q_data[$];
    logic [31:0] q_addr[$];
    int          q_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Log every read beat away from the active edge.
    always @(negedge clk) begin
        if (bus.rvalid === 1'b1) begin
            q_data.push_back(bus.rdata);
            q_addr.push_back(bus.raddr);
            q_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_raddr;
        logic [63:0] exp_base;
    } rd_vec_t;

    rd_vec_t vecs[5];

    function automatic logic [255:0] mk_line(input logic [63:0] b);
        return {b + 64'd3, b + 64'd2, b + 64'd1, b};
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic clear_log();
        q_data.delete();
        q_addr.delete();
        q_cyc.delete();
    endtask

    task automatic load(input logic [9:0] idx, input logic [255:0] line);
        load_en   = 1'b1;
        load_idx  = idx;
        load_data = line;
        step();
        load_en   = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int k = 0;
        while (bus.ready !== 1'b1 && k < 60) begin
            step();
            k++;
        end
        if (bus.ready !== 1'b1) fail_timeout(name);
    endtask

    task automatic do_read(input logic [31:0] a, output int acc);
        wait_ready("read_ready");
        bus.addr = a;
        bus.read = 1'b1;
        step();
        acc      = cyc;
        bus.read = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [255:0] line, input int nbeats);
        wait_ready("write_ready");
        bus.addr = a;
        for (int k = 0; k < nbeats; k++) begin
            bus.write = 1'b1;
            bus.wdata = line[k*64 +: 64];
            step();
        end
        bus.write = 1'b0;
        bus.wdata = '0;
    endtask

    task automatic wait_beats(input int n, input int budget, input string name);
        int k = 0;
        while (q_data.size() < n && k < budget) begin
            step();
            k++;
        end
        if (q_data.size() < n) fail_timeout(name);
    endtask

    task automatic check_burst(input string name, input int base, input logic [31:0] exp_addr,
                               input logic [255:0] exp_line);
        if (q_data.size() < base + 4) return;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s raddr beat%0d", name, k), 64'(q_addr[base+k]), 64'(exp_addr));
            check($sformatf("%s rdata beat%0d", name, k), q_data[base+k], exp_line[k*64 +: 64]);
        end
        check($sformatf("%s contiguous", name), 64'(q_cyc[base+3] - q_cyc[base]), 64'd3);
    endtask

    task automatic check_latency(input string name, input int acc);
        int lat;
        if (q_cyc.size() == 0) return;
        lat = q_cyc[0] - acc;
        check($sformatf("%s latency=%0d in range", name, lat), 64'(lat >= int'(LAT) && lat <= int'(LAT) + 2), 64'd1);
    endtask

    initial begin
        int acc;
        int acc0;
        int k;
        logic [255:0] wline;
        logic [31:0]  b2b_addr[4];
        logic [255:0] b2b_line[4];

        vecs[0] = '{addr: 32'h0000_00A0, exp_raddr: 32'h0000_00A0, exp_base: 64'h500};
        vecs[1] = '{addr: 32'h0000_00BF, exp_raddr: 32'h0000_00A0, exp_base: 64'h500};
        vecs[2] = '{addr: 32'h0000_80A0, exp_raddr: 32'h0000_80A0, exp_base: 64'h500};
        vecs[3] = '{addr: 32'h0000_7FE0, exp_raddr: 32'h0000_7FE0, exp_base: 64'hFFF0};
        vecs[4] = '{addr: 32'hFFFF_FFE0, exp_raddr: 32'hFFFF_FFE0, exp_base: 64'hFFF0};

        rst       = 1'b1;
        load_en   = 1'b0;
        load_idx  = '0;
        load_data = '0;
        bus.addr  = '0;
        bus.read  = 1'b0;
        bus.write = 1'b0;
        bus.wdata = '0;

        // Reset values.
        step(2);
        check("reset ready", 64'(bus.ready), 64'd0);
        check("reset rvalid", 64'(bus.rvalid), 64'd0);
        check("reset raddr", 64'(bus.raddr), 64'd0);
        check("reset rdata", bus.rdata, 64'd0);
        rst = 1'b0;
        step();
        check("ready after reset release", 64'(bus.ready), 64'd1);

        load(10'd5,    mk_line(64'h500));
        load(10'd8,    mk_line(64'h800));
        load(10'd1023, mk_line(64'hFFF0));
        load(10'd10,   mk_line(64'hA00));
        load(10'd2,    mk_line(64'h200));
        load(10'd4,    mk_line(64'h400));
        load(10'd1,    mk_line(64'h100));

        // Single reads: offset bits ignored, high address bits alias.
        for (int i = 0; i < 5; i++) begin
            clear_log();
            do_read(vecs[i].addr, acc);
            wait_beats(4, LAT + 20, $sformatf("vec%0d beats", i));
            check_latency($sformatf("vec%0d", i), acc);
            check_burst($sformatf("vec%0d", i), 0, vecs[i].exp_raddr, mk_line(vecs[i].exp_base));
            step(6);
            check($sformatf("vec%0d beat count", i), 64'(q_data.size()), 64'd4);
        end

        // Full write burst then read back.
        wline = {64'd4, 64'd3, 64'd2, 64'd1};
        do_write(32'h100, wline, 4);
        clear_log();
        do_read(32'h100, acc);
        wait_beats(4, LAT + 20, "wr100 beats");
        check_latency("wr100", acc);
        check_burst("wr100", 0, 32'h100, wline);

        // Four back-to-back reads fill the queue; 16 contiguous beats in order.
        b2b_addr[0] = 32'h00A0; b2b_line[0] = mk_line(64'h500);
        b2b_addr[1] = 32'h0100; b2b_line[1] = wline;
        b2b_addr[2] = 32'h7FE0; b2b_line[2] = mk_line(64'hFFF0);
        b2b_addr[3] = 32'h0140; b2b_line[3] = mk_line(64'hA00);
        clear_log();
        wait_ready("b2b ready");
        acc0 = 0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("b2b ready before accept %0d", i), 64'(bus.ready), 64'd1);
            bus.addr = b2b_addr[i];
            bus.read = 1'b1;
            step();
            if (i == 0) acc0 = cyc;
        end
        bus.read = 1'b0;
        check("b2b ready low when full", 64'(bus.ready), 64'd0);
        wait_beats(16, LAT + 40, "b2b beats");
        check_latency("b2b", acc0);
        for (int i = 0; i < 4; i++) begin
            check_burst($sformatf("b2b%0d", i), 4 * i, b2b_addr[i], b2b_line[i]);
        end
        if (q_cyc.size() >= 16) check("b2b 16 contiguous", 64'(q_cyc[15] - q_cyc[0]), 64'd15);
        check("b2b ready after drain", 64'(bus.ready), 64'd1);

        // Aborted write leaves the line untouched.
        do_write(32'h40, mk_line(64'h9990), 2);
        check("abort ready low mid-burst", 64'(bus.ready), 64'd0);
        step();
        check("abort ready back", 64'(bus.ready), 64'd1);
        clear_log();
        do_read(32'h40, acc);
        wait_beats(4, LAT + 20, "abort beats");
        check_burst("abort", 0, 32'h40, mk_line(64'h200));

        // Read data is sampled at accept, before a later write to the same line.
        clear_log();
        do_read(32'h80, acc);
        do_write(32'h80, mk_line(64'h4440), 4);
        wait_beats(4, LAT + 20, "rbw beats");
        check_burst("rbw old", 0, 32'h80, mk_line(64'h400));
        step(4);
        clear_log();
        do_read(32'h80, acc);
        wait_beats(4, LAT + 20, "rbw new beats");
        check_burst("rbw new", 0, 32'h80, mk_line(64'h4440));

        // Reset on beat 2 of a burst.
        clear_log();
        do_read(32'hA0, acc);
        k = 0;
        while (bus.rvalid !== 1'b1 && k < LAT + 20) begin
            step();
            k++;
        end
        if (bus.rvalid !== 1'b1) fail_timeout("rst burst start");
        step(2);
        check("rst beat2 data", bus.rdata, 64'h502);
        rst = 1'b1;
        step();
        check("rst rvalid", 64'(bus.rvalid), 64'd0);
        check("rst ready", 64'(bus.ready), 64'd0);
        rst = 1'b0;
        step();
        check("rst ready back", 64'(bus.ready), 64'd1);
        clear_log();
        step(LAT + 20);
        check("rst queue empty", 64'(q_data.size()), 64'd0);
        do_read(32'hA0, acc);
        wait_beats(4, LAT + 20, "rst array beats");
        check_burst("rst array intact", 0, 32'hA0, mk_line(64'h500));

        // read&write together: write wins, read is dropped.
        wline = mk_line(64'h2220);
        clear_log();
        wait_ready("rw ready");
        bus.addr  = 32'h20;
        bus.read  = 1'b1;
        bus.write = 1'b1;
        bus.wdata = wline[63:0];
        step();
        bus.read  = 1'b0;
        for (int i = 1; i < 4; i++) begin
            bus.wdata = wline[i*64 +: 64];
            step();
        end
        bus.write = 1'b0;
        step(LAT + 20);
        check("rw no read beats", 64'(q_data.size()), 64'd0);
        do_read(32'h20, acc);
        wait_beats(4, LAT + 20, "rw beats");
        check_burst("rw written", 0, 32'h20, wline);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
